// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and default timing for the LCD bus timer.
// Default cycle counts target a 50 MHz system clock.
package lcd_pkg;

    // Bus cycle phases, shared by the timer and the Avalon front end
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EHIGH,
        HOLD,
        RECOV,
        DONE
    } lcd_state_t;

    // HD44780 timing at 50 MHz (20 ns per clk)
    localparam int TAS_DEF  = 3;
    localparam int TEPW_DEF = 23;
    localparam int TAH_DEF  = 2;
    localparam int TCYC_DEF = 50;

    // Register-select encoding on LCD_RS
    localparam logic RS_INSTR = 1'b0;
    localparam logic RS_DATA  = 1'b1;

    // Picks the nibble carried by the current E pulse
    function automatic logic [3:0] nib_sel(
        input logic [7:0] b,
        input logic       lo
    );
        return lo ? b[3:0] : b[7:4];
    endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// lcd_cycle_timer: one LCD E-pulse sequence (setup, E high, hold,
// recovery) counted from the first setup cycle, then DONE or restart.
module lcd_cycle_timer
    import lcd_pkg::*;
#(
    parameter int TAS_CYC  = TAS_DEF,
    parameter int TEPW_CYC = TEPW_DEF,
    parameter int TAH_CYC  = TAH_DEF,
    parameter int TCYC_CYC = TCYC_DEF,
    parameter int CNT_W    = $clog2(TCYC_CYC + 1)
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_more,
    output lcd_state_t o_state,
    output logic       o_e,
    output logic       o_sample,
    output logic       o_fin
);

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_SET = CNT_W'(TAS_CYC);
    localparam logic [CNT_W-1:0] C_EHI = CNT_W'(TAS_CYC + TEPW_CYC);
    localparam logic [CNT_W-1:0] C_HLD =
        CNT_W'(TAS_CYC + TEPW_CYC + TAH_CYC);
    localparam logic [CNT_W-1:0] C_CYC = CNT_W'(TCYC_CYC);

    lcd_state_t       r_state;
    lcd_state_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt;
    logic             r_e;
    logic             w_fin;

    // Phase sequencing from the shared cycle counter
    always_comb begin
        w_next = r_state;
        w_fin  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_start) w_next = SETUP;
            end
            SETUP: begin
                if (r_cnt >= C_SET) w_next = EHIGH;
            end
            EHIGH: begin
                if (r_cnt >= C_EHI) w_next = HOLD;
            end
            HOLD: begin
                if (r_cnt >= C_HLD) begin
                    if (r_cnt >= C_CYC) begin
                        w_fin  = 1'b1;
                        w_next = i_more ? SETUP : DONE;
                    end else begin
                        w_next = RECOV;
                    end
                end
            end
            RECOV: begin
                if (r_cnt >= C_CYC) begin
                    w_fin  = 1'b1;
                    w_next = i_more ? SETUP : DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Counter restarts at 1 for each pulse and saturates at TCYC_CYC
    always_comb begin
        w_cnt = r_cnt;
        if (w_next == SETUP && (r_state == IDLE || w_fin)) begin
            w_cnt = C_ONE;
        end else if (w_next == IDLE || w_next == DONE) begin
            w_cnt = '0;
        end else if (r_cnt < C_CYC) begin
            w_cnt = r_cnt + C_ONE;
        end
    end

    // State, counter and registered E strobe
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_e     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_e     <= (w_next == EHIGH);
        end
    end

    assign o_state  = r_state;
    assign o_e      = r_e;
    assign o_fin    = w_fin;
    assign o_sample = (r_state == EHIGH) && (r_cnt == C_EHI);

endmodule

// File: rtl/lcd_bus_timer.sv
// lcd_bus_timer: Avalon-MM slave to HD44780 LCD bridge; latches each
// access, stalls the master and sequences 8-bit or two-nibble cycles.
module lcd_bus_timer
    import lcd_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TAS_CYC  = TAS_DEF,
    parameter int TEPW_CYC = TEPW_DEF,
    parameter int TAH_CYC  = TAH_DEF,
    parameter int TCYC_CYC = TCYC_DEF,
    parameter int CNT_W    = $clog2(TCYC_CYC + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [7:0]        writedata,
    output logic [7:0]        readdata,
    output logic              waitrequest,
    output logic              LCD_E,
    output logic              LCD_RS,
    output logic              LCD_RW,
    inout  wire  [DATA_W-1:0] LCD_data
);

    localparam bit NIBBLE = (DATA_W == 4);

    lcd_state_t        w_state;
    logic              w_req;
    logic              w_start;
    logic              w_more;
    logic              w_fin;
    logic              w_sample;
    logic              w_e;
    logic              w_oe;
    logic [DATA_W-1:0] w_dout;
    logic              w_unused;
    logic              r_rs;
    logic              r_rw;
    logic [7:0]        r_wdata;
    logic [7:0]        r_rdata;
    logic              r_nib;

    assign w_req    = read | write;
    assign w_start  = (w_state == IDLE) && w_req;
    assign w_more   = NIBBLE && !r_nib;
    assign w_unused = address[0];

    lcd_cycle_timer #(
        .TAS_CYC  (TAS_CYC),
        .TEPW_CYC (TEPW_CYC),
        .TAH_CYC  (TAH_CYC),
        .TCYC_CYC (TCYC_CYC),
        .CNT_W    (CNT_W)
    ) u_timer (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_start  (w_start),
        .i_more   (w_more),
        .o_state  (w_state),
        .o_e      (w_e),
        .o_sample (w_sample),
        .o_fin    (w_fin)
    );

    // Capture the access; write wins when read and write are both high
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rs    <= RS_INSTR;
            r_rw    <= 1'b0;
            r_wdata <= '0;
        end else if (w_start) begin
            r_rs    <= address[1] ? RS_DATA : RS_INSTR;
            r_rw    <= ~write;
            r_wdata <= writedata;
        end
    end

    // Second-nibble flag, set after the high nibble pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_nib <= 1'b0;
        end else if (w_fin && w_more) begin
            r_nib <= 1'b1;
        end else if (w_state == DONE) begin
            r_nib <= 1'b0;
        end
    end

    if (NIBBLE) begin : g_nib
        assign w_dout = nib_sel(r_wdata, r_nib);
        // Shift in high nibble first, low nibble second
        always_ff @(posedge clk) begin
            if (reset) begin
                r_rdata <= '0;
            end else if (w_sample && r_rw) begin
                r_rdata <= {r_rdata[3:0], LCD_data};
            end
        end
    end else begin : g_byte
        assign w_dout = r_wdata;
        // Whole byte sampled on the last E-high cycle
        always_ff @(posedge clk) begin
            if (reset) begin
                r_rdata <= '0;
            end else if (w_sample && r_rw) begin
                r_rdata <= LCD_data;
            end
        end
    end

    assign w_oe     = !r_rw && (w_state != IDLE);
    assign LCD_data = w_oe ? w_dout : {DATA_W{1'bz}};

    assign readdata    = r_rdata;
    assign waitrequest = w_req && (w_state != DONE);
    assign LCD_E       = w_e;
    assign LCD_RS      = r_rs;
    assign LCD_RW      = r_rw;

endmodule
